// File: rtl/fix_to_half_pkg.sv
// Shared types and constants for the fixed-point to binary16 converter.
// The state enum and result struct are also used by the adder's normalize stage.
package fix_to_half_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, PACK, DONE} state_t;

  localparam int BIAS   = 15;
  localparam int INT_W  = 16;
  localparam int FRAC_W = 32;
  localparam int MAG_W  = 48;
  localparam int CNT_W  = 6;
  localparam int P_MIN  = 18;
  localparam int P_STOP = 17;

  typedef struct packed {
    logic [15:0] half;
    logic        uf;
    logic        ovf;
  } half_res_t;

endpackage

// File: rtl/half_round_pack.sv
// Combinational binary16 packer: takes a left-justified magnitude plus its
// leading-one position and produces the half word with optional RNE rounding.
module half_round_pack
  import fix_to_half_pkg::*;
#(
  parameter bit ROUND_NEAREST = 1'b0
) (
  input  logic [MAG_W-1:0] mag,
  input  logic [CNT_W-1:0] cnt,
  input  logic             sign,
  input  logic             nz,
  output logic [15:0]      half,
  output logic             uf,
  output logic             ovf
);

  logic        normal;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [4:0]  exp_raw;
  logic [9:0]  mant_raw;
  logic [14:0] em_rnd;

  always_comb begin
    // A leading one at position 17 is 2^-15: below the normal range, so it flushes.
    normal   = mag[MAG_W-1] && (cnt >= CNT_W'(P_MIN));
    exp_raw  = 5'(int'(cnt) + BIAS - FRAC_W);
    mant_raw = mag[MAG_W-2 -: 10];
    guard    = mag[MAG_W-12];
    sticky   = |mag[MAG_W-13:0];
    round_up = ROUND_NEAREST && guard && (sticky || mant_raw[0]);
    em_rnd   = {exp_raw, mant_raw} + 15'(round_up);

    half = {sign, 15'b0};
    uf   = 1'b0;
    ovf  = 1'b0;
    if (normal) begin
      if (em_rnd[14:10] == 5'd31) begin
        half = {sign, 5'd31, 10'd0};
        ovf  = 1'b1;
      end else begin
        half = {sign, em_rnd};
      end
    end else begin
      uf = nz;
    end
  end

endmodule

// File: rtl/fix_to_half.sv
// Sign/integer/fraction to binary16 converter with a serial leading-one scan
// and valid/ready handshakes on both sides; feeds one operand of the fpa adder.
module fix_to_half
  import fix_to_half_pkg::*;
#(
  parameter bit ROUND_NEAREST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [INT_W-1:0]  in_int,
  input  logic [FRAC_W-1:0] in_frac,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_half,
  output logic              out_uf,
  output logic              out_ovf
);

  state_t           state_q, state_d;
  logic [MAG_W-1:0] mag_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sign_q;
  logic             nz_q;
  logic             vld_q;
  logic             scan_done;
  half_res_t        res_d, res_q;

  assign scan_done = mag_q[MAG_W-1] || (cnt_q == CNT_W'(P_STOP));

  half_round_pack #(.ROUND_NEAREST(ROUND_NEAREST)) u_pack (
    .mag  (mag_q),
    .cnt  (cnt_q),
    .sign (sign_q),
    .nz   (nz_q),
    .half (res_d.half),
    .uf   (res_d.uf),
    .ovf  (res_d.ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid)  state_d = SCAN;
      SCAN: if (scan_done) state_d = PACK;
      PACK:                state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q  <= '0;
      cnt_q  <= '0;
      sign_q <= 1'b0;
      nz_q   <= 1'b0;
      vld_q  <= 1'b0;
      res_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          sign_q <= in_sign;
          mag_q  <= {in_int, in_frac};
          nz_q   <= |{in_int, in_frac};
          cnt_q  <= CNT_W'(MAG_W - 1);
        end
        // Shift until the leading one reaches the MSB; cnt then names its position.
        SCAN: if (!scan_done) begin
          mag_q <= mag_q << 1;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        PACK: begin
          res_q <= res_d;
          vld_q <= 1'b1;
        end
        DONE: if (out_ready) vld_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = vld_q;
  assign out_half  = res_q.half;
  assign out_uf    = res_q.uf;
  assign out_ovf   = res_q.ovf;

endmodule

// File: tb/tb_fix_to_half.sv
// Directed bench for fix_to_half: a truncating and a round-to-nearest instance
// share one input stream and are compared against hand-computed results.
module tb_fix_to_half;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_sign, out_ready;
  logic [15:0] in_int;
  logic [31:0] in_frac;
  logic        in_ready_t, in_ready_r, out_valid_t, out_valid_r;
  logic        uf_t, uf_r, ovf_t, ovf_r;
  logic [15:0] half_t, half_r;
  int          total = 0;
  int          bad   = 0;

  // rt/rr = {half, uf, ovf} for the truncating / round-nearest instance
  typedef struct packed {
    logic        s;
    logic [15:0] i;
    logic [31:0] f;
    logic [17:0] rt;
    logic [17:0] rr;
    logic [5:0]  lat;
  } vec_t;

  always #5 clk = ~clk;

  fix_to_half #(.ROUND_NEAREST(1'b0)) u_trn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
    .in_sign(in_sign), .in_int(in_int), .in_frac(in_frac),
    .out_valid(out_valid_t), .out_ready(out_ready), .out_half(half_t),
    .out_uf(uf_t), .out_ovf(ovf_t)
  );

  fix_to_half #(.ROUND_NEAREST(1'b1)) u_rn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
    .in_sign(in_sign), .in_int(in_int), .in_frac(in_frac),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_half(half_r),
    .out_uf(uf_r), .out_ovf(ovf_r)
  );

  // Launch one operand, count edges to out_valid (bounded), capture and accept.
  task automatic do_op(input logic s, input logic [15:0] i, input logic [31:0] f,
                       output int lat, output logic [17:0] gt, output logic [17:0] gr);
    in_sign = s; in_int = i; in_frac = f; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_int = 16'hA5A5; in_frac = 32'h5A5A_5A5A; in_sign = ~s;
    lat = -1;
    for (int n = 1; n <= 60 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (out_valid_t && out_valid_r) lat = n;
    end
    gt = {half_t, uf_t, ovf_t};
    gr = {half_r, uf_r, ovf_r};
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_sign = 1'b0; in_int = '0; in_frac = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({in_ready_t, out_valid_t, half_t, uf_t, ovf_t} !== {1'b1, 1'b0, 18'h0}) begin
      bad++;
      $display("FAIL reset_trn: got rdy=%b vld=%b half=%h uf=%b ovf=%b want rdy=1 vld=0 half=0000 uf=0 ovf=0",
               in_ready_t, out_valid_t, half_t, uf_t, ovf_t);
    end
    total++;
    if ({in_ready_r, out_valid_r, half_r, uf_r, ovf_r} !== {1'b1, 1'b0, 18'h0}) begin
      bad++;
      $display("FAIL reset_rn: got rdy=%b vld=%b half=%h uf=%b ovf=%b want rdy=1 vld=0 half=0000 uf=0 ovf=0",
               in_ready_r, out_valid_r, half_r, uf_r, ovf_r);
    end
    rst = 1'b0;
  endtask

  task automatic test_normal();
    vec_t v[4];
    int lat;
    logic [17:0] gt, gr;
    v[0] = '{1'b0, 16'h0000, 32'hC28F5C28, {16'h3A14, 2'b00}, {16'h3A14, 2'b00}, 6'd18};
    v[1] = '{1'b1, 16'h0000, 32'h80000000, {16'hB800, 2'b00}, {16'hB800, 2'b00}, 6'd18};
    v[2] = '{1'b0, 16'h0001, 32'h00000000, {16'h3C00, 2'b00}, {16'h3C00, 2'b00}, 6'd17};
    v[3] = '{1'b0, 16'h0000, 32'h00040000, {16'h0400, 2'b00}, {16'h0400, 2'b00}, 6'd31};
    foreach (v[k]) begin
      do_op(v[k].s, v[k].i, v[k].f, lat, gt, gr);
      total++;
      if (lat != int'(v[k].lat)) begin
        bad++; $display("FAIL normal[%0d] latency: got %0d want %0d", k, lat, v[k].lat);
      end
      total++;
      if (gt !== v[k].rt) begin
        bad++; $display("FAIL normal[%0d] trn {half,uf,ovf}: got %h want %h", k, gt, v[k].rt);
      end
      total++;
      if (gr !== v[k].rr) begin
        bad++; $display("FAIL normal[%0d] rn {half,uf,ovf}: got %h want %h", k, gr, v[k].rr);
      end
    end
  endtask

  task automatic test_round();
    vec_t v[4];
    int lat;
    logic [17:0] gt, gr;
    v[0] = '{1'b0, 16'hFFFF, 32'h00000000, {16'h7BFF, 2'b00}, {16'h7C00, 2'b01}, 6'd2};
    v[1] = '{1'b0, 16'h8010, 32'h00000000, {16'h7800, 2'b00}, {16'h7800, 2'b00}, 6'd2};
    v[2] = '{1'b0, 16'h8030, 32'h00000000, {16'h7801, 2'b00}, {16'h7802, 2'b00}, 6'd2};
    v[3] = '{1'b1, 16'h8010, 32'h00000001, {16'hF800, 2'b00}, {16'hF801, 2'b00}, 6'd2};
    foreach (v[k]) begin
      do_op(v[k].s, v[k].i, v[k].f, lat, gt, gr);
      total++;
      if (lat != int'(v[k].lat)) begin
        bad++; $display("FAIL round[%0d] latency: got %0d want %0d", k, lat, v[k].lat);
      end
      total++;
      if (gt !== v[k].rt) begin
        bad++; $display("FAIL round[%0d] trn {half,uf,ovf}: got %h want %h", k, gt, v[k].rt);
      end
      total++;
      if (gr !== v[k].rr) begin
        bad++; $display("FAIL round[%0d] rn {half,uf,ovf}: got %h want %h", k, gr, v[k].rr);
      end
    end
  endtask

  task automatic test_underflow();
    vec_t v[3];
    int lat;
    logic [17:0] gt, gr;
    v[0] = '{1'b0, 16'h0000, 32'h00020000, {16'h0000, 2'b10}, {16'h0000, 2'b10}, 6'd32};
    v[1] = '{1'b0, 16'h0000, 32'h00001000, {16'h0000, 2'b10}, {16'h0000, 2'b10}, 6'd32};
    v[2] = '{1'b1, 16'h0000, 32'h00000000, {16'h8000, 2'b00}, {16'h8000, 2'b00}, 6'd32};
    foreach (v[k]) begin
      do_op(v[k].s, v[k].i, v[k].f, lat, gt, gr);
      total++;
      if (lat != int'(v[k].lat)) begin
        bad++; $display("FAIL underflow[%0d] latency: got %0d want %0d", k, lat, v[k].lat);
      end
      total++;
      if (gt !== v[k].rt) begin
        bad++; $display("FAIL underflow[%0d] trn {half,uf,ovf}: got %h want %h", k, gt, v[k].rt);
      end
      total++;
      if (gr !== v[k].rr) begin
        bad++; $display("FAIL underflow[%0d] rn {half,uf,ovf}: got %h want %h", k, gr, v[k].rr);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic stable;
    logic [17:0] gt, gr;
    in_sign = 1'b0; in_int = 16'h0001; in_frac = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 60 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (out_valid_t) lat = n;
    end
    total++;
    if (lat != 17) begin
      bad++; $display("FAIL backpressure latency: got %0d want 17", lat);
    end
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0]; in_int = 16'h4000; in_frac = 32'hFFFF_0000;
      @(posedge clk); #1;
      if (half_t !== 16'h3C00 || half_r !== 16'h3C00 || out_valid_t !== 1'b1 ||
          in_ready_t !== 1'b0 || in_ready_r !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    total++;
    if (stable !== 1'b1) begin
      bad++; $display("FAIL backpressure hold: got stable=%b want 1 (last half=%h rdy=%b)", stable, half_t, in_ready_t);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if ({out_valid_t, in_ready_t, out_valid_r, in_ready_r} !== 4'b0101) begin
      bad++; $display("FAIL backpressure handoff {vld,rdy,vld,rdy}: got %b want 0101",
                      {out_valid_t, in_ready_t, out_valid_r, in_ready_r});
    end
    do_op(1'b0, 16'h0000, 32'hC28F5C28, lat, gt, gr);
    total++;
    if (lat != 18 || gt !== {16'h3A14, 2'b00} || gr !== {16'h3A14, 2'b00}) begin
      bad++; $display("FAIL backpressure next op: got lat=%0d trn=%h rn=%h want lat=18 both=%h",
                      lat, gt, gr, {16'h3A14, 2'b00});
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic saw_vld;
    logic [17:0] gt, gr;
    in_sign = 1'b0; in_int = 16'h0000; in_frac = 32'h00001000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({in_ready_t, out_valid_t, half_t, uf_t, ovf_t} !== {1'b1, 1'b0, 18'h0}) begin
      bad++; $display("FAIL reset_mid trn: got rdy=%b vld=%b half=%h uf=%b ovf=%b want 1 0 0000 0 0",
                      in_ready_t, out_valid_t, half_t, uf_t, ovf_t);
    end
    total++;
    if ({in_ready_r, out_valid_r, half_r, uf_r, ovf_r} !== {1'b1, 1'b0, 18'h0}) begin
      bad++; $display("FAIL reset_mid rn: got rdy=%b vld=%b half=%h uf=%b ovf=%b want 1 0 0000 0 0",
                      in_ready_r, out_valid_r, half_r, uf_r, ovf_r);
    end
    rst = 1'b0;
    saw_vld = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid_t || out_valid_r) saw_vld = 1'b1;
    end
    total++;
    if (saw_vld !== 1'b0) begin
      bad++; $display("FAIL reset_mid aborted output: got out_valid seen=%b want 0", saw_vld);
    end
    do_op(1'b1, 16'h0000, 32'h80000000, lat, gt, gr);
    total++;
    if (lat != 18 || gt !== {16'hB800, 2'b00} || gr !== {16'hB800, 2'b00}) begin
      bad++; $display("FAIL reset_mid fresh op: got lat=%0d trn=%h rn=%h want lat=18 both=%h",
                      lat, gt, gr, {16'hB800, 2'b00});
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_round();
    test_underflow();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fix_to_half.md
Name: fix_to_half

Overview:
- Sequential sign/integer/fraction to IEEE-754 binary16 converter, directly upstream of the fpa half-precision adder.
- Produces the 16-bit operands that fpa consumes on its a/b inputs.
- Replaces the behavioural conversion loop with a synthesizable leading-one scan FSM using a valid/ready handshake.
- One instance per adder operand.

Parameters:
- ROUND_NEAREST, 0: 0 truncates the mantissa; 1 rounds to nearest, ties to even.

Ports:
- clk  in  1  Single clock; all state changes on the rising edge.
- rst  in  1  Reset, synchronous and active-high.
- in_valid  in  1  Input operand valid.
- in_ready  out  1  Block can accept an operand; high only in IDLE.
- in_sign  in  1  Sign of the operand (1 = negative).
- in_int  in  16  Unsigned integer part.
- in_frac  in  32  Unsigned fraction part; value = in_frac * 2^-32.
- out_valid  out  1  out_half/flags valid; held until accepted.
- out_ready  in  1  Downstream accepts the result.
- out_half  out  16  Result: {sign, exp[4:0], mant[9:0]}.
- out_uf  out  1  Nonzero magnitude below 2^-14, flushed to signed zero.
- out_ovf  out  1  Rounding carried the exponent to 31; result is signed infinity.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state = IDLE.
  - out_valid, out_half, out_uf, out_ovf = 0.
  - Internal shift register and counter cleared.
  - Reset aborts any conversion in progress with no output.
- States: IDLE, SCAN, PACK, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch sign, load mag[47:0] = {in_int, in_frac}, set nz = |mag, set cnt = 47, go to SCAN.
- SCAN, evaluated each cycle:
  - If mag[47] = 1 or cnt = 17, go to PACK.
  - Otherwise shift mag left by 1 and decrement cnt.
  - Leading-one position p equals cnt on exit.
  - At most 31 SCAN cycles.
- PACK:
  - Normal case (mag[47] = 1 and cnt >= 18):
    - exp = cnt - 17, giving 1..30.
    - mant = mag[46:37].
    - guard = mag[36].
    - sticky = |mag[35:0].
  - Rounding when ROUND_NEAREST = 1:
    - Round up when guard & (sticky | mant[0]).
    - Increment {exp, mant} as an 15-bit value.
    - If exp becomes 31: mant = 0, out_ovf = 1 (infinity).
  - When ROUND_NEAREST = 0, the mantissa is truncated and out_ovf is never set.
  - Zero or underflow case (mag[47] = 0):
    - out_half = {sign, 15'b0}.
    - out_uf = nz.
  - Results are registered and the FSM goes to DONE.
- DONE:
  - out_valid = 1; outputs are stable.
  - On out_ready go to IDLE and clear out_valid the following cycle.
  - No new input is accepted in the cycle of the handoff.
- Latency: counted in rising edges from the accept edge to out_valid high.
  - Normal result: 49 - p edges.
    - p = 47 gives 2 edges.
    - p = 18 gives 31 edges.
  - Zero or underflow: 32 edges.
- in_valid is ignored outside IDLE. Inputs need not be held after acceptance.
- Because in_int < 65536, out_ovf can only occur through rounding.

Decomposition:
- Package fix_to_half_pkg holds:
  - State enum {IDLE, SCAN, PACK, DONE}.
  - Constants: BIAS = 15, MAG_W = 48, FRAC_W = 32, P_MIN = 18, P_STOP = 17.
- One combinational sub-module, half_round_pack:
  - Inputs: mag, cnt, sign, nz, ROUND_NEAREST.
  - Outputs: half, uf, ovf.
  - Reused later by the adder's normalize stage.

Test Plan:
1. sign=0, int=0, frac=0xC28F5C28 (0.76), either rounding mode -> out_half=0x3A14, uf=0, ovf=0; out_valid 18 edges after accept.
2. sign=1, int=0, frac=0x80000000 (-0.5) -> 0xB800 after 18 edges. Then sign=0, int=1, frac=0 -> 0x3C00 after 17 edges.
3. int=0xFFFF, frac=0:
   - ROUND_NEAREST=0 -> 0x7BFF, ovf=0, after 2 edges.
   - ROUND_NEAREST=1 -> 0x7C00, ovf=1.
4. sign=0, int=0, frac=0x00001000 (2^-20) -> 0x0000, uf=1, after 32 edges. sign=1, zero magnitude -> 0x8000, uf=0.
5. Hold out_ready=0 for 10 cycles in DONE:
   - out_half stays stable and in_ready stays 0.
   - in_valid pulses are ignored.
   - After out_ready=1, the next operand is accepted and converted correctly.
6. Assert rst mid-SCAN:
   - Next edge gives state IDLE, in_ready=1, out_valid=0, all outputs 0.
   - A fresh conversion afterwards produces the correct result.
